// File: rtl/spu_mast_pipe.sv
// spu_mast_pipe: SPU modular-arithmetic store pipeline.
// Reads words from MA memory, writes them to the store buffer, and issues one
// store request per word. A credit limit (MAX_OUT) bounds the number of words
// that have been read but not yet acknowledged by the LSU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no operation since reset
// ST_RUN   | issuing memory reads while words remain
// ST_DRAIN | all reads issued; waiting for store requests and their acks
// ST_ABORT | terminated early; delay line flushed, waiting for pending acks
// ST_DONE  | operation complete; done/aborted flags held until next start
module spu_mast_pipe #(
  parameter int LEN_W   = 6,
  parameter int MAX_OUT = 2,
  parameter int RD_LAT  = 3
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             se,
  input  logic             spu_mactl_iss_pulse_dly,
  input  logic             mactl_stop,
  input  logic [LEN_W-1:0] spu_mactl_len,
  input  logic             streq_ack,
  input  logic             spu_wen_allma_stacks_ok,
  input  logic             spu_mactl_perr_set,
  input  logic             spu_mactl_stxa_force_abort,
  output logic             spu_mast_memren,
  output logic             spu_mast_maaddr_addrinc,
  output logic             spu_mast_stbuf_wen,
  output logic             spu_mast_streq,
  output logic             spu_mast_mpa_addrinc,
  output logic             spu_mast_done_set,
  output logic             spu_mast_aborted,
  output logic             spu_mast_busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [RD_LAT-1:0] dl_q, dl_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              mpa_q, mpa_d;
  logic              done_q, done_d;
  logic              done_dly_q, done_dly_d;
  logic              aborted_q, aborted_d;

  logic              start_ok;
  logic              abort_now;
  logic              memren;
  logic              streq;
  logic              ack_ok;
  logic [CNT_W:0]    outstanding;

  // Scan enable has no functional effect on this block.
  logic unused_se;
  assign unused_se = se;

  // A start is only honoured once the previous operation has finished.
  assign start_ok  = spu_mactl_iss_pulse_dly & mactl_stop &
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign abort_now = (spu_mactl_perr_set | spu_mactl_stxa_force_abort) &
                     ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  // Words in the read delay line plus words requested but not yet acked.
  assign outstanding = {1'b0, inflight_q} + {1'b0, pend_q};

  assign memren = (state_q == ST_RUN) && (rem_q != '0) &&
                  (outstanding < (CNT_W + 1)'(MAX_OUT)) && !abort_now;
  assign streq  = dl_q[RD_LAT-1] & ~abort_now;
  assign ack_ok = streq_ack & (pend_q != '0);

  // Datapath next-state: word counter, read delay line and credit counters.
  always_comb begin
    rem_d      = rem_q;
    dl_d       = {dl_q[RD_LAT-2:0], memren};
    inflight_d = inflight_q + CNT_W'(memren) - CNT_W'(dl_q[RD_LAT-1]);
    pend_d     = pend_q + CNT_W'(streq) - CNT_W'(ack_ok);
    mpa_d      = ack_ok & (state_q != ST_ABORT);
    done_dly_d = done_q;
    if (start_ok) begin
      rem_d = spu_mactl_len;
    end else if (abort_now) begin
      rem_d = '0;
    end else if (memren) begin
      rem_d = rem_q - LEN_W'(1);
    end
    if (abort_now) begin
      dl_d       = '0;
      inflight_d = '0;
    end
  end

  // FSM next-state plus the sticky done/aborted flags.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d = (spu_mactl_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_now) begin
          state_d = ST_ABORT;
        end else if (rem_d == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_now) begin
          state_d = ST_ABORT;
        end else if ((inflight_q == '0) && (pend_d == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_ABORT: begin
        if (pend_d == '0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_ok) begin
      done_d    = 1'b0;
      aborted_d = 1'b0;
    end
    if (abort_now) begin
      aborted_d = 1'b1;
    end
    // A zero-length start re-enters DONE, so it also counts as an entry.
    if ((state_d == ST_DONE) && ((state_q != ST_DONE) || start_ok)) begin
      done_d = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      dl_q       <= '0;
      inflight_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dl_q       <= dl_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
    end
  end

  // Registered status outputs.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      mpa_q      <= 1'b0;
      done_q     <= 1'b0;
      done_dly_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      mpa_q      <= mpa_d;
      done_q     <= done_d;
      done_dly_q <= done_dly_d;
      aborted_q  <= aborted_d;
    end
  end

  assign spu_mast_memren         = memren;
  assign spu_mast_maaddr_addrinc = memren;
  assign spu_mast_stbuf_wen      = dl_q[0];
  assign spu_mast_streq          = streq;
  assign spu_mast_mpa_addrinc    = mpa_q;
  assign spu_mast_done_set       = done_dly_q & spu_wen_allma_stacks_ok;
  assign spu_mast_aborted        = aborted_q;
  assign spu_mast_busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                                   (state_q == ST_ABORT);

endmodule
